// File: rtl/four_digit_scan.sv
// four_digit_scan: time-multiplexed scanner for a four-digit seven-segment
// display. It steps through the four nibbles of a shadowed 16-bit value one
// slot at a time. Each slot opens with a blanking interval. The shadow only
// changes on frame boundaries, so a frame never mixes old and new digits.
//
// The outputs (char, an, frame_done) are registered. Their next values are
// decoded from the next-state values of the scan registers. This way the
// registered outputs line up exactly with the state of the current cycle and
// add no extra cycle of latency.
//
// Note: with BLANK_CYCLES = 0, the first cycle after reset release still shows
// an = 4'b1111. That cycle's outputs were loaded while rst was high.

module four_digit_scan #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        lz_blank,
  output logic [3:0]  char,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int KW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [KW-1:0] K_LAST  = KW'(REFRESH_DIV - 1);
  localparam logic [KW-1:0] BLANK_K = KW'(BLANK_CYCLES);

  logic [KW-1:0] k_q, k_d;
  logic [1:0]    d_q, d_d;
  logic [15:0]   s_q, s_d;
  logic [15:0]   p_q, p_d;
  logic          pv_q, pv_d;

  logic [3:0]    char_q, char_d;
  logic [3:0]    an_q, an_d;
  logic          fd_q, fd_d;

  logic          slotEnd;
  logic          boundary;
  logic          digitOff;
  logic          inBlank;

  // Next-state logic for slot/digit stepping, shadow and pending registers.
  always_comb begin
    slotEnd  = (k_q == K_LAST);
    boundary = slotEnd && (d_q == 2'd3);

    k_d  = slotEnd ? '0 : k_q + KW'(1);
    d_d  = slotEnd ? d_q + 2'd1 : d_q;
    s_d  = s_q;
    p_d  = p_q;
    pv_d = pv_q;

    if (boundary) begin
      if (load) begin
        s_d = value;
      end else if (pv_q) begin
        s_d = p_q;
      end
      pv_d = 1'b0;
    end else if (load) begin
      p_d  = value;
      pv_d = 1'b1;
    end
  end

  // Decode the next cycle's display outputs from the next-state values.
  always_comb begin
    char_d = s_d[{d_d, 2'b00} +: 4];

    case (d_d)
      2'd1:    digitOff = (s_d[15:4] == 12'h000);
      2'd2:    digitOff = (s_d[15:8] == 8'h00);
      2'd3:    digitOff = (s_d[15:12] == 4'h0);
      default: digitOff = 1'b0;
    endcase

    inBlank = (k_d < BLANK_K);

    if (inBlank || (lz_blank && digitOff)) begin
      an_d = 4'b1111;
    end else begin
      an_d = ~(4'b0001 << d_d);
    end

    fd_d = (k_d == K_LAST) && (d_d == 2'd3);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q    <= '0;
      d_q    <= 2'd0;
      s_q    <= 16'h0000;
      p_q    <= 16'h0000;
      pv_q   <= 1'b0;
      char_q <= 4'h0;
      an_q   <= 4'b1111;
      fd_q   <= 1'b0;
    end else begin
      k_q    <= k_d;
      d_q    <= d_d;
      s_q    <= s_d;
      p_q    <= p_d;
      pv_q   <= pv_d;
      char_q <= char_d;
      an_q   <= an_d;
      fd_q   <= fd_d;
    end
  end

  assign char       = char_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_four_digit_scan.sv
// tb_four_digit_scan: self-checking bench for four_digit_scan. It runs with
// REFRESH_DIV=8 and BLANK_CYCLES=2. Expected per-cycle {an, char, frame_done}
// words are queued when each frame's stimulus is planned. Each word is popped
// and compared as the DUT produces that cycle.

module tb_four_digit_scan;

  localparam int RD  = 8;
  localparam int BC  = 2;
  localparam int FRM = 4 * RD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic [3:0]  char;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  logic [8:0] expQ[$];

  // Free-running clock with a period of 10 time units.
  always #5 clk = ~clk;

  four_digit_scan #(
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .load      (load),
    .lz_blank  (lz_blank),
    .char      (char),
    .an        (an),
    .frame_done(frame_done)
  );

  // Queue the expected {an, char, frame_done} for the first n cycles of a frame.
  task automatic pushFrame(input logic [15:0] s, input bit lz, input int n);
    for (int c = 0; c < n; c++) begin
      int d;
      int k;
      logic [15:0] sh;
      logic [3:0]  anExp;
      bit          off;
      d     = c / RD;
      k     = c % RD;
      sh    = s >> (4 * d);
      off   = lz && (d != 0) && (sh == 16'h0000);
      anExp = ((k < BC) || off) ? 4'b1111 : ~(4'b0001 << d);
      expQ.push_back({anExp, sh[3:0], (c == FRM - 1)});
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then wait for the falling edge.
  task automatic driveCycle(input bit ld, input logic [15:0] v, input bit lz);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    load     = ld;
    value    = v;
    lz_blank = lz;
    @(negedge clk);
  endtask

  // Hold reset for three cycles, then run one full frame of zeros.
  task automatic test_reset();
    logic [8:0] got;
    logic [8:0] exp;
    @(posedge clk);
    #1;
    rst      = 1'b1;
    load     = 1'b0;
    lz_blank = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      got = {an, char, frame_done};
      checks++;
      if (got !== 9'b1111_0000_0) begin
        failures++;
        $display("[TB] FAIL reset_hold got=%b required=%b", got, 9'b1111_0000_0);
      end
    end
    pushFrame(16'h0000, 1'b0, FRM);
    for (int c = 0; c < FRM; c++) begin
      driveCycle(1'b0, 16'h0000, 1'b0);
      got = {an, char, frame_done};
      exp = expQ.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL reset_release cyc=%0d got=%b required=%b", c, got, exp);
      end
    end
  endtask

  // Load 1234 mid-frame; the current frame still shows 0000.
  task automatic test_load_mid_frame();
    logic [8:0] got;
    logic [8:0] exp;
    pushFrame(16'h0000, 1'b0, FRM);
    for (int c = 0; c < FRM; c++) begin
      driveCycle(c == 10, 16'h1234, 1'b0);
      got = {an, char, frame_done};
      exp = expQ.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL load_mid_frame cyc=%0d got=%b required=%b", c, got, exp);
      end
    end
  endtask

  // Frame shows 1234 while loading AAAA then 5B0C; only the last load is kept.
  task automatic test_two_loads();
    logic [8:0] got;
    logic [8:0] exp;
    pushFrame(16'h1234, 1'b0, FRM);
    for (int c = 0; c < FRM; c++) begin
      driveCycle((c == 3) || (c == 20), (c == 3) ? 16'hAAAA : 16'h5B0C, 1'b0);
      got = {an, char, frame_done};
      exp = expQ.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL two_loads cyc=%0d got=%b required=%b", c, got, exp);
      end
    end
  endtask

  // Frame shows 5B0C and BEEF is loaded on its frame_done cycle; the next frame shows BEEF.
  task automatic test_boundary_load();
    logic [8:0]  got;
    logic [8:0]  exp;
    logic [15:0] shown [2];
    shown[0] = 16'h5B0C;
    shown[1] = 16'hBEEF;
    for (int f = 0; f < 2; f++) begin
      pushFrame(shown[f], 1'b0, FRM);
      for (int c = 0; c < FRM; c++) begin
        if (f == 0) begin
          driveCycle(c == FRM - 1, 16'hBEEF, 1'b0);
        end else begin
          driveCycle(c == 5, 16'h0050, c == FRM - 1);
        end
        got = {an, char, frame_done};
        exp = expQ.pop_front();
        checks++;
        if (got !== exp) begin
          failures++;
          $display("[TB] FAIL boundary_load frame=%0d cyc=%0d got=%b required=%b", f, c, got, exp);
        end
      end
    end
  endtask

  // Leading-zero blanking over values 0050, 0000 and 1000, with boundary loads.
  task automatic test_lz_blank();
    logic [8:0]  got;
    logic [8:0]  exp;
    logic [15:0] vals [4];
    vals[0] = 16'h0050;
    vals[1] = 16'h0000;
    vals[2] = 16'h1000;
    vals[3] = 16'h1000;
    for (int f = 0; f < 3; f++) begin
      pushFrame(vals[f], 1'b1, FRM);
      for (int c = 0; c < FRM; c++) begin
        driveCycle((c == FRM - 1) && (f < 2), vals[f + 1], 1'b1);
        got = {an, char, frame_done};
        exp = expQ.pop_front();
        checks++;
        if (got !== exp) begin
          failures++;
          $display("[TB] FAIL lz_blank val=%h cyc=%0d got=%b required=%b", vals[f], c, got, exp);
        end
      end
    end
  endtask

  // Reset during slot d=2 with 9999 pending; the pending value must never appear.
  task automatic test_reset_mid_frame();
    logic [8:0] got;
    logic [8:0] exp;
    pushFrame(16'h1000, 1'b1, 18);
    for (int c = 0; c < 18; c++) begin
      driveCycle(c == 5, 16'h9999, 1'b1);
      got = {an, char, frame_done};
      exp = expQ.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL pre_abort cyc=%0d got=%b required=%b", c, got, exp);
      end
    end
    test_reset();
    pushFrame(16'h0000, 1'b0, FRM);
    for (int c = 0; c < FRM; c++) begin
      driveCycle(1'b0, 16'h0000, 1'b0);
      got = {an, char, frame_done};
      exp = expQ.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL after_abort cyc=%0d got=%b required=%b", c, got, exp);
      end
    end
  endtask

  // Run all scenarios in order, then print the summary.
  initial begin
    test_reset();
    test_load_mid_frame();
    test_two_loads();
    test_boundary_load();
    test_lz_blank();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Abort the run if it ever stops advancing.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/four_digit_scan.md
# four_digit_scan

Time-multiplexing scanner for the four-digit seven-segment display.
- Holds a 16-bit hex value and steps through its four nibbles, one digit slot at a time.
- Presents the active nibble on `char` to the downstream Decoder_7_Segment and drives the matching active-low anode.
- Inserts a blanking interval at the start of each slot to suppress ghosting.
- Updates the displayed value only on frame boundaries, so no frame ever mixes old and new digits.

## Interface
Parameters:
- `REFRESH_DIV`, default 50000: clock cycles per digit slot; legal range ≥ 2.
- `BLANK_CYCLES`, default 1000: cycles at the start of each slot with all anodes off; legal range 0 ≤ BLANK_CYCLES < REFRESH_DIV. A value of 0 disables blanking.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `value` in 16: hex value to display; `value[3:0]` is the rightmost digit (digit 0).
- `load` in 1: single-cycle strobe that captures `value`.
- `lz_blank` in 1: when 1, leading-zero digits are blanked.
- `char` out 4: nibble for the current digit, feeding the decoder's `char` input.
- `an` out 4: anode enables, active-low; `an[i]` selects digit i.
- `frame_done` out 1: one-cycle pulse at each frame boundary.

## Operation
State:
- Slot counter k, range 0..REFRESH_DIV-1.
- Digit index d, range 0..3.
- Shadow register S (16 bits): the value being displayed.
- Pending register P (16 bits) with valid flag pv.

Slot stepping:
- k increments every cycle.
- At k = REFRESH_DIV-1, k wraps to 0 and d advances 0→1→2→3→0.

Frame boundary:
- Defined as the cycle where d wraps 3→0.
- On that cycle: S ← value if `load`=1; else S ← P if pv=1; else S holds. pv clears.
- `frame_done`=1 for exactly that cycle.

Load handling:
- `load`=1 on any non-boundary cycle: P ← value, pv ← 1.
- Multiple loads within one frame: the last one wins.

Outputs:
- `char` = S[4d+3:4d] for the whole slot, blanking interval included.
- `an` = 4'b1111 when k < BLANK_CYCLES or when digit d is blanked; otherwise `an` = ~(1<<d).

Leading-zero blanking (`lz_blank`=1):
- Digit d>0 is blanked when S[4d+3:4d] and every higher nibble of S are zero.
- Digit 0 is never blanked.
- Blanking is evaluated from S, so it is constant within a frame.
- `lz_blank` is sampled every cycle; a change takes effect on the next cycle.

Reset:
- During `rst`: k=0, d=0, S=0, P=0, pv=0, `an`=4'b1111, `char`=4'h0, `frame_done`=0.
- `rst` mid-frame aborts the frame and drops any pending load.
- `rst` has priority over `load`.

## Timing
- All outputs are flop-driven with no combinational path from inputs. A one-stage output register is allowed, provided it is applied uniformly to `an`, `char` and `frame_done`.
- The first cycle after `rst` deasserts is k=0, d=0. This cycle is not a frame boundary and does not pulse `frame_done`.
- Slot length is REFRESH_DIV cycles. Frame length is 4·REFRESH_DIV cycles.
- Each slot shows BLANK_CYCLES cycles with `an`=1111, then REFRESH_DIV−BLANK_CYCLES cycles with the active anode.
- `char` changes only at slot start, always while `an`=1111 (when BLANK_CYCLES>0).
- Load latency: a load on a non-boundary cycle is displayed starting at the next frame boundary. A load on the boundary cycle is displayed in the frame that begins on that cycle.
- The first `frame_done` after reset occurs 4·REFRESH_DIV−1 cycles after reset release. Subsequent pulses are every 4·REFRESH_DIV cycles.

## Test plan
All scenarios use REFRESH_DIV=8 and BLANK_CYCLES=2.

1. Reset: hold `rst` for 3 cycles.
   - During reset: `an`=1111, `char`=0, `frame_done`=0.
   - After release: `an`=1111 for 2 cycles, then 1110 for 6 cycles, then 1111 for 2 cycles, then 1101, and so on.
   - First `frame_done` falls on cycle 31 after release.
2. Load 16'h1234 mid-frame:
   - The current frame still shows 0000.
   - From the next boundary, slots show char 4/3/2/1 with `an` 1110/1101/1011/0111.
   - The new digits are never mixed into the old frame.
3. Two loads in one frame, 16'hAAAA then 16'h5B0C: the next frame shows C,0,B,5. The value AAAA is never displayed.
4. Load 16'hBEEF on the exact `frame_done` cycle: that same new frame shows F,E,E,B.
5. Leading-zero blanking, `lz_blank`=1:
   - Value 16'h0050: digits 3 and 2 keep `an`=1111 for the full slot; digit 1 shows 5 (`an`=1101); digit 0 shows 0 (`an`=1110).
   - Value 16'h0000: only digit 0 is lit.
   - Value 16'h1000 with `lz_blank`=1: all four digits are lit.
6. Reset mid-frame during slot d=2 with a pending load:
   - Next cycles match scenario 1 with S=0.
   - The pending value is never displayed.
